// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl
//   Host-side controller for a PLL dynamic reconfiguration port (DRP).
//   Each accepted host request becomes a single DRP read or write. The last
//   write of a batch then pulses the PLL reset and waits for the PLL to relock,
//   with a timeout. The block issues exactly one response pulse per request.
//   dclk of the DRP is the same clock as sys_clk.
//
// Optional feature macro: PLL_DRP_READBACK_EN
//   When defined, every write is followed by a read of the same address.
//   A readback value that differs from the written data sets rsp_err.
//
// Parameters
//   RST_CYCLES   : cycles pll_reset is held after a batch (2..255)
//   LOCK_TIMEOUT : cycles to wait for lock before flagging an error (1..65535)
//
// Ports
//   sys_clk, sys_rst_n         : clock, async active-low reset
//   req_valid/req_ready        : host request handshake
//   req_we/addr/wdata/last     : request fields (last only meaningful on writes)
//   rsp_valid/rsp_rdata/rsp_err: one-cycle response with read data and error
//   pll_dcs/dwe/daddr/di/do    : DRP port
//   pll_reset                  : PLL reset, active high
//   pll_extlock                : asynchronous PLL lock input
//   locked                     : synchronized lock
//   busy                       : high whenever a request is in flight

module pll_drp_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       req_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       pll_dcs,
  output logic       pll_dwe,
  output logic [5:0] pll_daddr,
  output logic [7:0] pll_di,
  input  logic [7:0] pll_do,
  output logic       pll_reset,
  input  logic       pll_extlock,
  output logic       locked,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_CAP,
    ST_PRST,
    ST_LOCK,
    ST_RESP
  } state_t;

  // Terminal counts. The counter starts at 0 on state entry, so the last
  // cycle of a state of length N sees N-1.
  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        last_q, last_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        rd_phase;

`ifdef PLL_DRP_READBACK_EN
  // Set while the controller runs the verification read that follows a write.
  logic        rb_q, rb_d;
  assign rd_phase = rb_q;
`else
  assign rd_phase = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
`ifdef PLL_DRP_READBACK_EN
      rb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
`ifdef PLL_DRP_READBACK_EN
      rb_q    <= rb_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    sync1_d = pll_extlock;
    sync2_d = sync1_q;
`ifdef PLL_DRP_READBACK_EN
    rb_d    = rb_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          last_d  = req_last;
          err_d   = 1'b0;
`ifdef PLL_DRP_READBACK_EN
          rb_d    = 1'b0;
`endif
          state_d = ST_ACC;
        end
      end

      ST_ACC: state_d = ST_CAP;

      ST_CAP: begin
        // Writes report zero read data; reads return what the DRP drove.
        rdata_d = we_q ? 8'h00 : pll_do;
        if (!we_q) begin
          state_d = ST_RESP;
`ifdef PLL_DRP_READBACK_EN
        end else if (!rb_q) begin
          rb_d    = 1'b1;
          state_d = ST_ACC;
`endif
        end else begin
`ifdef PLL_DRP_READBACK_EN
          if (pll_do != wdata_q) err_d = 1'b1;
`endif
          cnt_d   = '0;
          state_d = last_q ? ST_PRST : ST_RESP;
        end
      end

      ST_PRST: begin
        if (cnt_q >= RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOCK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // The counter is never cleared inside LOCK, so a lock that drops and
      // returns does not extend the wait. The lock level decides the outcome.
      ST_LOCK: begin
        if (sync2_q) begin
          state_d = ST_RESP;
        end else if (cnt_q >= LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // The outputs decode the registered state only. pll_reset therefore falls
  // as soon as the asynchronous reset forces the state back to IDLE.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign pll_dcs   = (state_q == ST_ACC);
  assign pll_dwe   = (state_q == ST_ACC) & we_q & ~rd_phase;
  assign pll_daddr = (state_q == ST_ACC) ? addr_q : 6'h00;
  assign pll_di    = (state_q == ST_ACC) ? wdata_q : 8'h00;
  assign pll_reset = (state_q == ST_PRST);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) & err_q;
  assign rsp_rdata = rdata_q;
  assign locked    = sync2_q;

endmodule

// File: doc/pll_drp_ctrl.md
PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles pll_reset is held after a batch; legal range 2..255.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles to wait for lock before flagging an error; legal range 1..65535.
REQ-003 sys_clk  in  1  sole clock; the PLL DRP dclk is driven from this same clock outside the block.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  host request valid.
REQ-006 req_ready  out  1  host request accepted on the edge where req_valid&req_ready.
REQ-007 req_we  in  1  1 = register write, 0 = register read.
REQ-008 req_addr  in  6  PLL configuration register address.
REQ-009 req_wdata  in  8  write data.
REQ-010 req_last  in  1  last write of a batch; triggers the PLL reset/relock sequence (ignored on reads).
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_rdata  out  8  read data; valid with rsp_valid.
REQ-013 rsp_err  out  1  error flag; valid with rsp_valid.
REQ-014 pll_dcs, pll_dwe  out  1 each  DRP select and write enable.
REQ-015 pll_daddr  out  6  DRP address.
REQ-016 pll_di  out  8  DRP write data.
REQ-017 pll_do  in  8  DRP read data.
REQ-018 pll_reset  out  1  PLL reset, active high.
REQ-019 pll_extlock  in  1  asynchronous PLL lock.
REQ-020 locked  out  1  pll_extlock after a 2-flop synchronizer.
REQ-021 busy  out  1  high in every FSM state except IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ACC, CAP, PRST, LOCK and RESP; req_ready SHALL be high only in IDLE.
REQ-023 On accept, the block SHALL latch we/addr/wdata/last and enter ACC.
REQ-024 ACC SHALL last exactly one cycle, with pll_dcs=1, pll_dwe=we, and pll_daddr/pll_di driven from the latches; all DRP outputs SHALL be 0 in every other state.
REQ-025 CAP SHALL last one cycle; a read SHALL sample pll_do into rsp_rdata at the end of CAP.
REQ-026 Leaving CAP, the FSM SHALL go to PRST if we&last, otherwise to RESP.
REQ-027 PRST SHALL hold pll_reset=1 for exactly RST_CYCLES cycles, then go to LOCK.
REQ-028 LOCK SHALL wait until locked=1 (success, go to RESP) or until LOCK_TIMEOUT cycles have elapsed (go to RESP with rsp_err=1).
REQ-029 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE.
REQ-030 Minimum latency SHALL be 3 cycles from accept to rsp_valid for a non-last access.
REQ-031 The timeout counter SHALL be 16 bits, SHALL clear on entry to LOCK, and SHALL saturate (no wrap).
REQ-032 A locked 1->0 drop while in LOCK SHALL NOT restart the timeout; only the final condition counts.
REQ-033 rsp_rdata SHALL hold its last value outside RESP; on writes it SHALL be 0.
REQ-034 req_valid presented while busy SHALL be ignored; no queuing.

Reset
REQ-035 sys_rst_n low SHALL force IDLE immediately (mid-operation included); all outputs 0 except req_ready=1; synchronizer and counters cleared.
REQ-036 A reset during PRST SHALL release pll_reset asynchronously; no response SHALL be issued for the aborted request.

Configuration
REQ-037 With PLL_DRP_READBACK_EN defined, every write SHALL be followed by a read of the same address: one additional ACC cycle (dwe=0) plus one CAP cycle, inserted before PRST/RESP.
REQ-038 Under PLL_DRP_READBACK_EN, a readback mismatch against wdata SHALL set rsp_err=1, and the mismatch SHALL be ORed with the lock timeout error; write latency becomes 5 cycles.
REQ-039 Without PLL_DRP_READBACK_EN, writes SHALL NOT perform readback, and rsp_err SHALL reflect only the lock timeout.

Verification
REQ-040 Read addr 0x05 with pll_do=0xA7 -> one cycle with dcs=1, dwe=0, daddr=0x05; rsp_valid 3 cycles after accept; rsp_rdata=0xA7; rsp_err=0.
REQ-041 Write 0x12 to 0x03 with last=0 -> dcs=dwe=1, di=0x12; no pll_reset; rsp_valid with rsp_err=0.
REQ-042 Write with last=1 and lock asserted 10 cycles after reset release -> pll_reset high exactly 16 cycles; rsp_valid after locked rises; rsp_err=0.
REQ-043 LOCK_TIMEOUT=100, lock never asserts -> rsp_valid with rsp_err=1 exactly 100 cycles after entering LOCK.
REQ-044 sys_rst_n pulsed low during PRST -> pll_reset=0, busy=0 and req_ready=1 immediately; no rsp_valid.
REQ-045 With PLL_DRP_READBACK_EN, write 0x55 and readback 0x54 -> two dcs pulses (dwe 1 then 0); rsp_err=1.
